// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data memory for the MEM stage.
// Supports RISC-V byte/half/word loads and stores with sign or zero extension.
// Requests use a req/ready handshake, and load responses are registered.
// Misaligned, out-of-range and reserved-size accesses return an error response.
// After reset, a sequential clear engine zeroes the whole array.
// A combinational debug port reads any aligned word of the array.
// Optional feature macro: DMEM_STATS_EN adds saturating load/store/error counters.
module data_memory_ctrl #(
   parameter int  DEPTH_BYTES       = 256,
   parameter int  CLR_BYTES_PER_CYC = 4,
   localparam int AW                = $clog2(DEPTH_BYTES)
) (
   input  logic          clk_i,
   input  logic          reset,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [1:0]    size_i,
   input  logic          unsigned_i,
   input  logic [31:0]   addr_i,
   input  logic [31:0]   wdata_i,
   output logic          ready_o,
   output logic          rvalid_o,
   output logic [31:0]   rdata_o,
   output logic          err_o,
   output logic          clr_busy_o,
   input  logic [AW-1:0] dbg_addr_i,
   output logic [31:0]   dbg_data_o
`ifdef DMEM_STATS_EN
  ,output logic [15:0]   ld_cnt_o,
   output logic [15:0]   st_cnt_o,
   output logic [15:0]   err_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [AW-1:0] CLR_STEP = AW'(CLR_BYTES_PER_CYC);
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH_BYTES - CLR_BYTES_PER_CYC);
   localparam logic [31:0]   DEPTH_W  = 32'(DEPTH_BYTES);

   // Extend the raw little-endian bytes according to access size and signedness
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [1:0]  size,
                                               input logic        uns);
      logic [31:0] res;
      case (size)
         2'b00:   res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         2'b10:   res = raw;
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   logic [7:0]    mem_r [DEPTH_BYTES];
   state_t        state_r;
   logic [AW-1:0] clr_ptr_r;
   logic          ready_r;
   logic          clr_busy_r;
   logic          rvalid_r;
   logic          err_r;
   logic [31:0]   rdata_r;

   logic          misalign_s;
   logic          range_s;
   logic          rsvd_s;
   logic          acc_err_s;
   logic          accept_s;
   logic          st_we_s;
   logic          clr_we_s;
   logic [AW-1:0] idx_s;
   logic [31:0]   raw_s;
   logic [31:0]   load_data_s;
   logic          unused_dbg_s;

   assign idx_s    = addr_i[AW-1:0];
   assign accept_s = req_i && ready_r && (state_r == ST_IDLE);
   assign st_we_s  = accept_s && we_i && !acc_err_s && !reset;
   assign clr_we_s = (state_r == ST_CLEAR) && !reset;

   // The byte lanes are addressed by replacing low index bits, so an aligned access never wraps
   assign raw_s = {mem_r[{idx_s[AW-1:2], 2'b11}], mem_r[{idx_s[AW-1:2], 2'b10}],
                   mem_r[{idx_s[AW-1:1], 1'b1}],  mem_r[idx_s]};
   assign load_data_s = extend_load(raw_s, size_i, unsigned_i);

   assign dbg_data_o = {mem_r[{dbg_addr_i[AW-1:2], 2'b11}], mem_r[{dbg_addr_i[AW-1:2], 2'b10}],
                        mem_r[{dbg_addr_i[AW-1:2], 2'b01}], mem_r[{dbg_addr_i[AW-1:2], 2'b00}]};
   assign unused_dbg_s = ^dbg_addr_i[1:0];

   // Classify the presented access as misaligned, out of range or reserved size
   always_comb begin
      misalign_s = 1'b0;
      case (size_i)
         2'b01:   misalign_s = addr_i[0];
         2'b10:   misalign_s = (addr_i[1:0] != 2'b00);
         default: misalign_s = 1'b0;
      endcase
      range_s   = (addr_i >= DEPTH_W);
      rsvd_s    = (size_i == 2'b11);
      acc_err_s = misalign_s | range_s | rsvd_s;
   end

   // Array writes: clear-engine zeroing and committed stores; reset alone never writes the array
   always_ff @(posedge clk_i) begin
      if (clr_we_s) begin
         for (int k = 0; k < CLR_BYTES_PER_CYC; k++) begin
            mem_r[clr_ptr_r + AW'(k)] <= 8'h00;
         end
      end else if (st_we_s) begin
         case (size_i)
            2'b00: mem_r[idx_s] <= wdata_i[7:0];
            2'b01: begin
               mem_r[idx_s]                    <= wdata_i[7:0];
               mem_r[{idx_s[AW-1:1], 1'b1}]    <= wdata_i[15:8];
            end
            2'b10: begin
               mem_r[{idx_s[AW-1:2], 2'b00}]   <= wdata_i[7:0];
               mem_r[{idx_s[AW-1:2], 2'b01}]   <= wdata_i[15:8];
               mem_r[{idx_s[AW-1:2], 2'b10}]   <= wdata_i[23:16];
               mem_r[{idx_s[AW-1:2], 2'b11}]   <= wdata_i[31:24];
            end
            default: ;
         endcase
      end
   end

   // Control FSM (CLEAR -> IDLE <-> RESP) with all handshake and response outputs registered
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_r    <= ST_CLEAR;
         clr_ptr_r  <= {AW{1'b0}};
         ready_r    <= 1'b0;
         clr_busy_r <= 1'b1;
         rvalid_r   <= 1'b0;
         err_r      <= 1'b0;
         rdata_r    <= 32'd0;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               clr_ptr_r <= clr_ptr_r + CLR_STEP;
               if (clr_ptr_r == CLR_LAST) begin
                  state_r    <= ST_IDLE;
                  ready_r    <= 1'b1;
                  clr_busy_r <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (accept_s) begin
                  if (acc_err_s) begin
                     rdata_r  <= 32'd0;
                     err_r    <= 1'b1;
                     rvalid_r <= 1'b1;
                     ready_r  <= 1'b0;
                     state_r  <= ST_RESP;
                  end else if (!we_i) begin
                     rdata_r  <= load_data_s;
                     rvalid_r <= 1'b1;
                     ready_r  <= 1'b0;
                     state_r  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               rvalid_r <= 1'b0;
               err_r    <= 1'b0;
               ready_r  <= 1'b1;
               state_r  <= ST_IDLE;
            end
            default: begin
               state_r    <= ST_CLEAR;
               clr_ptr_r  <= {AW{1'b0}};
               ready_r    <= 1'b0;
               clr_busy_r <= 1'b1;
               rvalid_r   <= 1'b0;
               err_r      <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o    = ready_r;
   assign rvalid_o   = rvalid_r;
   assign err_o      = err_r;
   assign rdata_o    = rdata_r;
   assign clr_busy_o = clr_busy_r;

`ifdef DMEM_STATS_EN
   logic [15:0] ld_cnt_r;
   logic [15:0] st_cnt_r;
   logic [15:0] err_cnt_r;

   // Saturating event counters, bumped on each accepted request
   always_ff @(posedge clk_i) begin
      if (reset) begin
         ld_cnt_r  <= 16'd0;
         st_cnt_r  <= 16'd0;
         err_cnt_r <= 16'd0;
      end else if (accept_s) begin
         if (acc_err_s) begin
            if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
         end else if (we_i) begin
            if (st_cnt_r != 16'hFFFF) st_cnt_r <= st_cnt_r + 16'd1;
         end else begin
            if (ld_cnt_r != 16'hFFFF) ld_cnt_r <= ld_cnt_r + 16'd1;
         end
      end
   end

   assign ld_cnt_o  = ld_cnt_r;
   assign st_cnt_o  = st_cnt_r;
   assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and randomized checks of data_memory_ctrl
// against a byte-array reference model of the load/store rules.
module tb_data_memory_ctrl;

   localparam int DEPTH = 256;

   logic        clk_i = 1'b0;
   logic        reset;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        clr_busy_o;
   logic [7:0]  dbg_addr_i;
   logic [31:0] dbg_data_o;

   logic [7:0]  mem_m [DEPTH];
   int          n_checks = 0;
   int          n_fail   = 0;

   data_memory_ctrl dut (
      .clk_i      (clk_i),
      .reset      (reset),
      .req_i      (req_i),
      .we_i       (we_i),
      .size_i     (size_i),
      .unsigned_i (unsigned_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .ready_o    (ready_o),
      .rvalid_o   (rvalid_o),
      .rdata_o    (rdata_o),
      .err_o      (err_o),
      .clr_busy_o (clr_busy_o),
      .dbg_addr_i (dbg_addr_i),
      .dbg_data_o (dbg_data_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int a);
      int b = a & ~3;
      return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
   endfunction

   // Little-endian gather, then two's-complement sign extension by arithmetic
   function automatic logic [31:0] model_load(input int a, input int n, input bit uns);
      longint v = 0;
      for (int k = 0; k < n; k++) v = v + (longint'(mem_m[a+k]) << (8*k));
      if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
      return v[31:0];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
   endtask

   task automatic chk_dbg(input string tag, input logic [7:0] a, input logic [31:0] exp);
      dbg_addr_i = a;
      #1;
      chk(tag, dbg_data_o, exp);
   endtask

   // Called right after reset release; counts edges until ready_o rises
   task automatic check_clear(input string tag);
      int cnt = 0;
      bit busy_ok = 1'b1;
      while (ready_o !== 1'b1 && cnt < 200) begin
         if (clr_busy_o !== 1'b1) busy_ok = 1'b0;
         @(posedge clk_i); #1;
         cnt++;
      end
      chk({tag, "_cycles"}, cnt, 64);
      chk({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
      chk({tag, "_busy_after"}, {31'd0, clr_busy_o}, 32'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready_o !== 1'b1 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("ready_wait", {31'd0, ready_o}, 32'd1);
   endtask

   // One request through the handshake, checked against the model
   task automatic acc(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e);
      int n;
      logic exp_err;
      logic [31:0] exp_rd;
      @(negedge clk_i);
      wait_ready();
      req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
      n = 1 << sz;
      exp_err = (sz == 2'b11) || (addr >= 32'(DEPTH)) || ((addr % n) != 0);
      exp_rd  = 32'd0;
      if (!exp_err && !we) exp_rd = model_load(int'(addr), n, uns);
      @(posedge clk_i); #1;
      req_i = 1'b0;
      rd = rdata_o;
      e  = err_o;
      if (!exp_err && we) begin
         for (int k = 0; k < n; k++) mem_m[int'(addr)+k] = wd[8*k +: 8];
         chk("st_rvalid", {31'd0, rvalid_o}, 32'd0);
         chk("st_ready", {31'd0, ready_o}, 32'd1);
         chk_dbg("st_dbg", addr[7:0], model_word(int'(addr[7:0])));
      end else begin
         chk("rsp_rvalid", {31'd0, rvalid_o}, 32'd1);
         chk("rsp_err", {31'd0, err_o}, {31'd0, exp_err});
         chk("rsp_rdata", rdata_o, exp_rd);
         chk("rsp_ready", {31'd0, ready_o}, 32'd0);
         @(posedge clk_i); #1;
         chk("post_rvalid", {31'd0, rvalid_o}, 32'd0);
         chk("post_err", {31'd0, err_o}, 32'd0);
         chk("post_rdata_hold", rdata_o, exp_rd);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      logic [31:0] ra;
      logic [31:0] rw;
      logic [1:0]  rs;
      int          r;

      reset = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = 32'd0; wdata_i = 32'd0; dbg_addr_i = 8'd0;

      // Reset held for two edges, then the full clear window
      repeat (2) @(negedge clk_i);
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_busy", {31'd0, clr_busy_o}, 32'd1);
      chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      reset = 1'b0;
      check_clear("clear_init");
      model_clear();
      chk_dbg("dbg_00_clr", 8'h00, 32'd0);
      chk_dbg("dbg_fc_clr", 8'hFC, 32'd0);

      // Word store / load, then debug view at an unaligned debug address
      acc(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, e);
      acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e);
      chk("lw_10", rd, 32'hDEADBEEF);
      chk_dbg("dbg_12", 8'h12, 32'hDEADBEEF);

      // Byte and half extension
      acc(1'b1, 2'b10, 1'b0, 32'h20, 32'h0080F0FF, rd, e);
      acc(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, e);
      chk("lb_20", rd, 32'hFFFFFFFF);
      acc(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, e);
      chk("lbu_20", rd, 32'h000000FF);
      acc(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, e);
      chk("lh_22", rd, 32'h00000080);
      acc(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, rd, e);
      chk("lb_22", rd, 32'hFFFFFF80);
      acc(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, e);
      chk("lh_20", rd, 32'hFFFFF0FF);
      acc(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, e);
      chk("lhu_20", rd, 32'h0000F0FF);

      // Partial stores use only the low bytes of wdata
      acc(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, rd, e);
      acc(1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAA, rd, e);
      acc(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234BEEF, rd, e);
      acc(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, e);
      chk("lw_30_partial", rd, 32'hBEEFAA44);

      // Error responses
      acc(1'b0, 2'b10, 1'b0, 32'h31, 32'h0, rd, e);
      chk("lw_31_err", {31'd0, e}, 32'd1);
      chk("lw_31_rdata", rd, 32'd0);
      acc(1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF, rd, e);
      chk("sw_100_err", {31'd0, e}, 32'd1);
      acc(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, e);
      chk("lw_00_unchanged", rd, 32'd0);
      acc(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, rd, e);
      chk("rsvd_err", {31'd0, e}, 32'd1);
      acc(1'b1, 2'b01, 1'b0, 32'h43, 32'h5555, rd, e);
      chk("sh_43_err", {31'd0, e}, 32'd1);

      // Top-of-array boundaries
      acc(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D, rd, e);
      acc(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, rd, e);
      chk("lb_ff", rd, 32'hFFFFFFCA);
      acc(1'b0, 2'b01, 1'b1, 32'hFE, 32'h0, rd, e);
      chk("lhu_fe", rd, 32'h0000CAFE);
      acc(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, rd, e);
      chk("lb_100_err", {31'd0, e}, 32'd1);

      // Randomized traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) ra = $urandom;
         else if (r == 1) ra = 32'(DEPTH) + 32'($urandom_range(0, 7));
         else ra = 32'($urandom_range(0, DEPTH - 1));
         r  = $urandom_range(0, 15);
         rs = (r == 15) ? 2'b11 : 2'(r % 3);
         if (rs != 2'b11 && $urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
         rw = $urandom;
         acc(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, rw, rd, e);
      end

      // Reset in the middle of a clear restarts the full window
      acc(1'b1, 2'b10, 1'b0, 32'hFC, 32'h5A5AA5A5, rd, e);
      @(negedge clk_i); reset = 1'b1;
      @(negedge clk_i); reset = 1'b0;
      repeat (30) @(posedge clk_i);
      #1;
      chk_dbg("midclr_dbg_00", 8'h00, 32'd0);
      chk_dbg("midclr_dbg_fc", 8'hFC, 32'h5A5AA5A5);
      chk("midclr_busy", {31'd0, clr_busy_o}, 32'd1);
      @(negedge clk_i); reset = 1'b1;
      @(posedge clk_i); #1;
      chk("midclr_rst_busy", {31'd0, clr_busy_o}, 32'd1);
      chk("midclr_rst_ready", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i); reset = 1'b0;
      check_clear("clear_restart");
      model_clear();
      chk_dbg("dbg_fc_after", 8'hFC, 32'd0);

      // Reset during a response cycle drops the pulse at the next edge
      acc(1'b1, 2'b10, 1'b0, 32'h10, 32'h87654321, rd, e);
      @(negedge clk_i);
      wait_ready();
      req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h10;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      chk("resp_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("resp_rdata", rdata_o, 32'h87654321);
      @(negedge clk_i); reset = 1'b1;
      @(posedge clk_i); #1;
      chk("resp_rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("resp_rst_rdata", rdata_o, 32'd0);
      chk("resp_rst_ready", {31'd0, ready_o}, 32'd0);
      chk("resp_rst_busy", {31'd0, clr_busy_o}, 32'd1);
      @(negedge clk_i); reset = 1'b0;
      check_clear("clear_after_resp");
      model_clear();
      acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e);
      chk("lw_10_cleared", rd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-addressable data memory for the core's MEM stage. It adds the RISC-V load/store sizes (byte, half, word) with sign or zero extension, and a request/ready handshake with a registered read response. Misaligned and out-of-range accesses are flagged as errors. After reset, a sequential clear engine zeroes the array. A combinational debug word port supports display and test.

Parameters:
DEPTH_BYTES, 256, number of bytes in the array; power of two, minimum 8.
AW, $clog2(DEPTH_BYTES), internal byte-address width (derived; not overridden).
CLR_BYTES_PER_CYC, 4, bytes zeroed per clear cycle; one of 1, 2, 4.

Ports:
clk_i  in  1  clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
req_i  in  1  access request; accepted on a cycle where req_i && ready_o.
we_i  in  1  1 = store, 0 = load; sampled at accept.
size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error).
unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
addr_i  in  32  byte address.
wdata_i  in  32  store data; the low bytes are used per size_i.
ready_o  out  1  block can accept a request this cycle.
rvalid_o  out  1  one-cycle pulse marking a load response or an error response.
rdata_o  out  32  extended load data; valid only while rvalid_o = 1.
err_o  out  1  qualifies rvalid_o: the access was misaligned, out of range or reserved.
clr_busy_o  out  1  the clear engine is running.
dbg_addr_i  in  AW  debug byte address; bits [1:0] are ignored.
dbg_data_o  out  32  little-endian word at {dbg_addr_i[AW-1:2],2'b00}; combinational.

Behaviour:
- State machine: CLEAR -> IDLE <-> RESP.
- Reset:
  - While reset = 1 at a clock edge: state <= CLEAR, clear pointer <= 0.
  - rvalid_o, err_o and rdata_o <= 0; ready_o = 0; clr_busy_o = 1.
  - The array is not written by the reset itself.
- CLEAR:
  - Each cycle, CLR_BYTES_PER_CYC bytes starting at the pointer are written to 0, and the pointer advances by the same amount.
  - After the cycle that writes the last byte (DEPTH_BYTES - 1), state -> IDLE.
  - Total clear time is DEPTH_BYTES / CLR_BYTES_PER_CYC cycles; ready_o = 0 and req_i is ignored throughout.
  - Reset asserted mid-clear restarts the clear from pointer 0.
- IDLE:
  - ready_o = 1.
  - On accept, the error check is evaluated first:
    - misaligned: half with addr_i[0] = 1, or word with addr_i[1:0] != 0;
    - out of range: addr_i >= DEPTH_BYTES;
    - reserved: size_i = 11.
  - Store, no error: bytes addr .. addr + n - 1 <= wdata_i[8n-1:0] at the accept edge, little-endian. No response is generated and state stays IDLE, so stores may be accepted back-to-back.
  - Load, no error: bytes are read at the accept edge, extended, and registered into rdata_o; state -> RESP.
  - Any error (load or store): the array is not modified; rdata_o <= 0; err_o <= 1; state -> RESP.
- RESP:
  - rvalid_o = 1 for exactly this one cycle; ready_o = 0. Next cycle: state -> IDLE, rvalid_o and err_o <= 0.
  - Load-to-response latency is 1 cycle; load throughput is one load per 2 cycles.
  - rdata_o holds its value after the pulse until the next load.
- Extension:
  - byte: 24 copies of bit 7 (sign), or 24 zeros (unsigned).
  - half: 16 copies of bit 15 (sign), or 16 zeros (unsigned).
  - word: passed through unchanged; unsigned_i is ignored.
- Store followed by load to the same address: the load accepted in the next cycle returns the new data (the write is already committed).
- Debug port:
  - Reads the array directly, including during CLEAR, where it shows partially cleared contents.
  - A store's effect is visible on dbg_data_o from the cycle after its accept.
- Address arithmetic: byte indices are computed in AW bits. An in-range, aligned access never wraps.

Optional Feature:
DMEM_STATS_EN
- Defined:
  - Adds output ports ld_cnt_o [15:0], st_cnt_o [15:0] and err_cnt_o [15:0].
  - Each counter saturates at 16'hFFFF and clears on reset.
  - Increments on accept: successful load, successful store, or any error, respectively.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset and clear: hold reset 2 cycles, then release -> clr_busy_o = 1 and ready_o = 0 for exactly 64 cycles (DEPTH_BYTES = 256), then ready_o = 1. dbg_data_o at 0x00 and 0xFC reads 0.
- Word store/load: SW 0xDEADBEEF to 0x10, then LW 0x10 -> rvalid_o pulses 1 cycle after the load accept with rdata_o = 0xDEADBEEF and err_o = 0. dbg_addr_i = 0x12 also shows 0xDEADBEEF.
- Byte and half extension: SW 0x0080F0FF to 0x20, then:
  - LB 0x20 -> 0xFFFFFFFF; LBU 0x20 -> 0x000000FF;
  - LH 0x22 -> 0x00000080; LB 0x22 -> 0xFFFFFF80.
- Partial store: SW 0x11223344 to 0x30, SB 0xAA to 0x31, SH 0xBEEF to 0x32 (low bytes of wdata_i) -> LW 0x30 returns 0xBEEFAA44.
- Errors:
  - LW 0x31 -> rvalid_o = 1, err_o = 1, rdata_o = 0.
  - SW 0x0000_0100 -> rvalid_o = 1, err_o = 1, and the array is unchanged (LW 0x00 returns 0).
  - size_i = 11 -> err_o = 1.
- Reset mid-operation: assert reset during clear cycle 30 and also in the RESP cycle -> rvalid_o drops to 0 next edge, and the clear restarts with the full 64-cycle busy window.
